// File: rtl/fft_mem_ctl.sv
// 64-point FFT frame sequencer: loads 64 samples, runs 8 row + 8 column passes through an
// 8-point engine via a 1x8 memory port, then unloads digit-reversed; out stream has no backpressure.
module fft_mem_ctl #(
  parameter int DATA_WD = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 dat_vld_i,
  input  logic [DATA_WD-1:0]   dat_dat_i,
  output logic                 dat_rdy_o,
  output logic                 out_vld_o,
  output logic [DATA_WD-1:0]   out_dat_o,
  output logic                 out_last_o,
  output logic                 eng_vld_o,
  output logic [8*DATA_WD-1:0] eng_dat_o,
  output logic                 eng_pass_o,
  output logic [2:0]           eng_idx_o,
  input  logic                 eng_vld_i,
  input  logic [8*DATA_WD-1:0] eng_dat_i,
  output logic                 mem_dim_sel_o,
  output logic [2:0]           mem_adr_1x8_o,
  output logic                 mem_rd_vld_1x8_o,
  input  logic                 mem_rd_vld_1x8_i,
  input  logic [8*DATA_WD-1:0] mem_rd_dat_1x8_i,
  output logic                 mem_wr_vld_1x8_o,
  output logic [8*DATA_WD-1:0] mem_wr_dat_1x8_o,
  output logic [5:0]           mem_adr_1x1_o,
  output logic                 mem_rd_vld_1x1_o,
  input  logic                 mem_rd_vld_1x1_i,
  input  logic [DATA_WD-1:0]   mem_rd_dat_1x1_i,
  output logic                 mem_wr_vld_1x1_o,
  output logic [DATA_WD-1:0]   mem_wr_dat_1x1_o
);

  typedef enum logic [2:0] {IDLE, LOAD, RD, EXE, WR, UNLOAD, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   pass_q, pass_d;
  logic [2:0]             idx_q, idx_d;
  logic [5:0]             cnt_q, cnt_d;
  logic                   drain_q, drain_d;
  logic                   issued_q, issued_d;
  logic                   eng_vld_q, eng_vld_d;
  logic [8*DATA_WD-1:0]   line_q, line_d;

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    issued_d  = issued_q;
    eng_vld_d = 1'b0;
    line_d    = line_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD;
          pass_d   = 1'b0;
          idx_d    = 3'd0;
          cnt_d    = 6'd0;
          drain_d  = 1'b0;
          issued_d = 1'b0;
        end
      end
      LOAD: begin
        if (dat_vld_i) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            state_d = RD;
            pass_d  = 1'b0;
            idx_d   = 3'd0;
          end
        end
      end
      RD: begin
        state_d  = EXE;
        issued_d = 1'b0;
      end
      EXE: begin
        // A result is only accepted strictly after the request cycle.
        if (!issued_q && mem_rd_vld_1x8_i) begin
          line_d    = mem_rd_dat_1x8_i;
          eng_vld_d = 1'b1;
          issued_d  = 1'b1;
        end else if (issued_q && !eng_vld_q && eng_vld_i) begin
          line_d   = eng_dat_i;
          issued_d = 1'b0;
          state_d  = WR;
        end
      end
      WR: begin
        if (idx_q == 3'd7) begin
          idx_d = 3'd0;
          if (pass_q) begin
            state_d = UNLOAD;
            cnt_d   = 6'd0;
            drain_d = 1'b0;
          end else begin
            pass_d  = 1'b1;
            state_d = RD;
          end
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = RD;
        end
      end
      UNLOAD: begin
        // After 64 reads, hold one more cycle for the last read data to return.
        if (!drain_q) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) drain_d = 1'b1;
        end else if (mem_rd_vld_1x1_i) begin
          drain_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pass_q    <= 1'b0;
      idx_q     <= 3'd0;
      cnt_q     <= 6'd0;
      drain_q   <= 1'b0;
      issued_q  <= 1'b0;
      eng_vld_q <= 1'b0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      issued_q  <= issued_d;
      eng_vld_q <= eng_vld_d;
      line_q    <= line_d;
    end
  end

  logic load_wr;
  logic unload_rd;

  assign load_wr   = (state_q == LOAD) && dat_vld_i;
  assign unload_rd = (state_q == UNLOAD) && !drain_q;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign dat_rdy_o = (state_q == LOAD);

  assign mem_wr_vld_1x1_o = load_wr;
  assign mem_wr_dat_1x1_o = load_wr ? dat_dat_i : '0;
  assign mem_rd_vld_1x1_o = unload_rd;
  assign mem_adr_1x1_o    = load_wr   ? cnt_q :
                            unload_rd ? {cnt_q[2:0], cnt_q[5:3]} : 6'd0;

  assign mem_rd_vld_1x8_o = (state_q == RD);
  assign mem_wr_vld_1x8_o = (state_q == WR);
  assign mem_adr_1x8_o    = idx_q;
  assign mem_dim_sel_o    = pass_q;
  assign mem_wr_dat_1x8_o = line_q;

  assign eng_vld_o  = eng_vld_q;
  assign eng_dat_o  = line_q;
  assign eng_pass_o = pass_q;
  assign eng_idx_o  = idx_q;

  assign out_vld_o  = busy_o && mem_rd_vld_1x1_i;
  assign out_dat_o  = busy_o ? mem_rd_dat_1x1_i : '0;
  assign out_last_o = out_vld_o && (state_q == UNLOAD) && drain_q;

endmodule

// File: tb/tb_fft_mem_ctl.sv
// Directed bench for fft_mem_ctl with behavioural 64-entry memory and 8-point engine models.
module tb_fft_mem_ctl;

  localparam int W  = 10;
  localparam int LW = 8 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          busy_o, done_o;
  logic          dat_vld_i = 1'b0;
  logic [W-1:0]  dat_dat_i = '0;
  logic          dat_rdy_o;
  logic          out_vld_o, out_last_o;
  logic [W-1:0]  out_dat_o;
  logic          eng_vld_o, eng_pass_o;
  logic [LW-1:0] eng_dat_o;
  logic [2:0]    eng_idx_o;
  logic          eng_vld_i;
  logic [LW-1:0] eng_dat_i;
  logic          mem_dim_sel_o;
  logic [2:0]    mem_adr_1x8_o;
  logic          mem_rd_vld_1x8_o;
  logic          mem_rd_vld_1x8_i = 1'b0;
  logic [LW-1:0] mem_rd_dat_1x8_i = '0;
  logic          mem_wr_vld_1x8_o;
  logic [LW-1:0] mem_wr_dat_1x8_o;
  logic [5:0]    mem_adr_1x1_o;
  logic          mem_rd_vld_1x1_o;
  logic          mem_rd_vld_1x1_i = 1'b0;
  logic [W-1:0]  mem_rd_dat_1x1_i = '0;
  logic          mem_wr_vld_1x1_o;
  logic [W-1:0]  mem_wr_dat_1x1_o;

  fft_mem_ctl #(.DATA_WD(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .dat_vld_i(dat_vld_i), .dat_dat_i(dat_dat_i), .dat_rdy_o(dat_rdy_o),
    .out_vld_o(out_vld_o), .out_dat_o(out_dat_o), .out_last_o(out_last_o),
    .eng_vld_o(eng_vld_o), .eng_dat_o(eng_dat_o), .eng_pass_o(eng_pass_o), .eng_idx_o(eng_idx_o),
    .eng_vld_i(eng_vld_i), .eng_dat_i(eng_dat_i),
    .mem_dim_sel_o(mem_dim_sel_o), .mem_adr_1x8_o(mem_adr_1x8_o),
    .mem_rd_vld_1x8_o(mem_rd_vld_1x8_o), .mem_rd_vld_1x8_i(mem_rd_vld_1x8_i),
    .mem_rd_dat_1x8_i(mem_rd_dat_1x8_i), .mem_wr_vld_1x8_o(mem_wr_vld_1x8_o),
    .mem_wr_dat_1x8_o(mem_wr_dat_1x8_o), .mem_adr_1x1_o(mem_adr_1x1_o),
    .mem_rd_vld_1x1_o(mem_rd_vld_1x1_o), .mem_rd_vld_1x1_i(mem_rd_vld_1x1_i),
    .mem_rd_dat_1x1_i(mem_rd_dat_1x1_i), .mem_wr_vld_1x1_o(mem_wr_vld_1x1_o),
    .mem_wr_dat_1x1_o(mem_wr_dat_1x1_o)
  );

  always #5 clk = ~clk;

  // Memory model: element (r,c) lives at 8*r+c; read latency one cycle.
  logic [W-1:0] mem [64];

  function automatic int ma8(input logic dim, input logic [2:0] line, input int k);
    return dim ? (k * 8 + int'(line)) : (int'(line) * 8 + k);
  endfunction

  always @(posedge clk) begin
    if (mem_wr_vld_1x1_o) mem[mem_adr_1x1_o] <= mem_wr_dat_1x1_o;
    if (mem_wr_vld_1x8_o)
      for (int k = 0; k < 8; k++)
        mem[ma8(mem_dim_sel_o, mem_adr_1x8_o, k)] <= mem_wr_dat_1x8_o[k*W +: W];
    mem_rd_vld_1x1_i <= mem_rd_vld_1x1_o;
    if (mem_rd_vld_1x1_o) mem_rd_dat_1x1_i <= mem[mem_adr_1x1_o];
    mem_rd_vld_1x8_i <= mem_rd_vld_1x8_o;
    if (mem_rd_vld_1x8_o)
      for (int k = 0; k < 8; k++)
        mem_rd_dat_1x8_i[k*W +: W] <= mem[ma8(mem_dim_sel_o, mem_adr_1x8_o, k)];
  end

  // Engine model: adds eng_add to every element, result after eng_lat cycles.
  int            eng_lat = 1;
  int            eng_add = 0;
  int            eng_cnt = 0;
  logic          eng_vld_m = 1'b0;
  logic [LW-1:0] eng_dat_m = '0;
  bit            spur_en = 1'b0;
  logic          spur;

  function automatic logic [LW-1:0] eng_f(input logic [LW-1:0] d, input int add);
    logic [LW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*W +: W] = d[k*W +: W] + W'(add);
    return r;
  endfunction

  always @(posedge clk) begin
    if (eng_vld_o) begin
      eng_dat_m <= eng_f(eng_dat_o, eng_add);
      eng_cnt   <= eng_lat - 1;
      eng_vld_m <= (eng_lat == 1);
    end else if (eng_cnt > 0) begin
      eng_cnt   <= eng_cnt - 1;
      eng_vld_m <= (eng_cnt == 1);
    end else begin
      eng_vld_m <= 1'b0;
    end
  end

  assign spur      = spur_en && (mem_rd_vld_1x8_o || mem_wr_vld_1x8_o);
  assign eng_vld_i = eng_vld_m || spur;
  assign eng_dat_i = spur ? '1 : eng_dat_m;

  // Monitor, sampled on the falling edge.
  logic [5:0]   wr_adr_q[$];
  logic [W-1:0] wr_dat_q[$];
  logic [W-1:0] out_q[$];
  logic         last_q[$];
  logic [3:0]   eng_q[$];
  int           done_cnt = 0;
  int           last_cnt = 0;
  int           overlap = 0;

  always @(negedge clk) begin
    if (mem_wr_vld_1x1_o) begin
      wr_adr_q.push_back(mem_adr_1x1_o);
      wr_dat_q.push_back(mem_wr_dat_1x1_o);
    end
    if (out_vld_o) begin
      out_q.push_back(out_dat_o);
      last_q.push_back(out_last_o);
    end
    if (out_last_o) last_cnt++;
    if (eng_vld_o) eng_q.push_back({eng_pass_o, eng_idx_o});
    if (done_o) done_cnt++;
    if (int'(mem_wr_vld_1x1_o) + int'(mem_rd_vld_1x1_o) +
        int'(mem_wr_vld_1x8_o) + int'(mem_rd_vld_1x8_o) > 1) overlap++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_adr_q.delete(); wr_dat_q.delete(); out_q.delete(); last_q.delete(); eng_q.delete();
    done_cnt = 0; last_cnt = 0; overlap = 0;
  endtask

  // Pulse start then stream 64 samples (value = index); caller is at posedge+1.
  task automatic start_and_load(input bit gap);
    int  i;
    int  cyc;
    bit  acc;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    i = 0; cyc = 0;
    while (i < 64 && cyc < 1000) begin
      dat_vld_i = !gap || (cyc % 2 == 0);
      dat_dat_i = dat_vld_i ? W'(i) : W'(10'h155);
      @(negedge clk);
      acc = dat_vld_i && dat_rdy_o;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    dat_vld_i = 1'b0;
    dat_dat_i = '0;
    check("load_accepts", 64'(i), 64'd64);
  endtask

  task automatic run_frame(input string nm, input int lat, input int add, input bit gap, input bit noise);
    int w;
    int n;
    clear_mon();
    eng_lat = lat; eng_add = add; spur_en = noise;
    start_and_load(gap);
    if (noise) begin
      for (int c = 0; c < 24; c++) begin
        dat_vld_i = 1'b1;
        dat_dat_i = W'(10'h3aa);
        start_i   = (c == 5) || (c == 17);
        @(posedge clk); #1;
      end
      dat_vld_i = 1'b0; dat_dat_i = '0; start_i = 1'b0;
    end
    w = 0;
    while (done_cnt == 0 && w < 4000) begin
      @(posedge clk); #1;
      w++;
    end
    check({nm, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    spur_en = 1'b0;
    check({nm, "_done_once"}, 64'(done_cnt), 64'd1);
    check({nm, "_busy_after"}, 64'(busy_o), 64'd0);
    check({nm, "_wr_count"}, 64'(wr_adr_q.size()), 64'd64);
    for (int k = 0; k < 64 && k < wr_adr_q.size(); k++) begin
      check($sformatf("%s_wr_adr%0d", nm, k), 64'(wr_adr_q[k]), 64'(k));
      check($sformatf("%s_wr_dat%0d", nm, k), 64'(wr_dat_q[k]), 64'(k));
    end
    check({nm, "_eng_count"}, 64'(eng_q.size()), 64'd16);
    for (int k = 0; k < 16 && k < eng_q.size(); k++)
      check($sformatf("%s_eng%0d", nm, k), 64'(eng_q[k]), 64'({k >= 8, 3'(k % 8)}));
    check({nm, "_out_count"}, 64'(out_q.size()), 64'd64);
    for (n = 0; n < 64 && n < out_q.size(); n++)
      check($sformatf("%s_out%0d", nm, n), 64'(out_q[n]),
            64'((((n % 8) * 8) + (n / 8)) + 2 * add));
    check({nm, "_last_count"}, 64'(last_cnt), 64'd1);
    if (last_q.size() == 64) check({nm, "_last_pos"}, 64'(last_q[63]), 64'd1);
    check({nm, "_strobe_overlap"}, 64'(overlap), 64'd0);
  endtask

  initial begin
    int w;
    #2;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_rdy", 64'(dat_rdy_o), 64'd0);
    check("rst_eng_vld", 64'(eng_vld_o), 64'd0);
    check("rst_buses", 64'(|{eng_dat_o, mem_wr_dat_1x8_o, mem_wr_dat_1x1_o, out_dat_o,
                             mem_adr_1x1_o, mem_adr_1x8_o}), 64'd0);
    check("rst_strobes", 64'(|{mem_rd_vld_1x8_o, mem_wr_vld_1x8_o, mem_rd_vld_1x1_o,
                               mem_wr_vld_1x1_o, out_vld_o, out_last_o}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("ident", 1, 0, 1'b0, 1'b0);
    run_frame("add1", 5, 1, 1'b0, 1'b0);
    run_frame("gap", 2, 0, 1'b1, 1'b0);
    run_frame("noise", 1, 0, 1'b0, 1'b1);

    // Reset in the middle of the unload phase.
    clear_mon();
    eng_lat = 1; eng_add = 0;
    start_and_load(1'b0);
    w = 0;
    while (out_q.size() < 10 && w < 4000) begin
      @(posedge clk); #1;
      w++;
    end
    check("mid_unload_reached", 64'(out_q.size() >= 10), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_out_vld", 64'(out_vld_o), 64'd0);
    check("mrst_out_dat", 64'(out_dat_o), 64'd0);
    check("mrst_rd_1x1", 64'(mem_rd_vld_1x1_o), 64'd0);
    check("mrst_adr_1x1", 64'(mem_adr_1x1_o), 64'd0);
    check("mrst_buses", 64'(|{eng_dat_o, mem_wr_dat_1x8_o, mem_adr_1x8_o, mem_dim_sel_o}), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mrst_no_done", 64'(done_cnt), 64'd0);
    check("mrst_idle", 64'(busy_o), 64'd0);
    run_frame("after_rst", 1, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
